cmp_pipe: RTL and testbench

CMP_PIPE -- requirements
Module: cmp_pipe

---
 rtl/cmp_pipe_if.sv | 28 ++
 rtl/cmp_pipe.sv | 100 ++++++++++
 tb/tb_cmp_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_pipe_if.sv
// Bundle of the cmp_pipe streaming signals: operands/opcode in with a valid/ready
// handshake, comparison result out with its own valid/ready, plus the true-result count.
interface cmp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_signed;
  logic             in_valid;
  logic             in_ready;
  logic             out_z;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] true_count;

  modport master (
    output in_a, in_b, in_op, in_signed, in_valid, out_ready,
    input  in_ready, out_z, out_err, out_valid, true_count
  );

  modport slave (
    input  in_a, in_b, in_op, in_signed, in_valid, out_ready,
    output in_ready, out_z, out_err, out_valid, true_count
  );
endinterface

// File: rtl/cmp_pipe.sv
// Pipelined WIDTH-bit comparator: result is computed combinationally, then carried
// through STAGES valid/payload registers; counts delivered results that were true.
module cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic      clk,
  input  logic      rst,
  cmp_pipe_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {z, err}; EQ/NE look only at equality so they ignore the signed flag.
  function automatic logic [1:0] cmp_result(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op,
    input logic             sgn
  );
    logic lt;
    logic eq;
    eq = (a == b);
    if (sgn) begin
      lt = ($signed(a) < $signed(b));
    end else begin
      lt = (a < b);
    end
    case (op)
      3'd0:    cmp_result = {lt, 1'b0};
      3'd1:    cmp_result = {lt | eq, 1'b0};
      3'd2:    cmp_result = {eq, 1'b0};
      3'd3:    cmp_result = {~eq, 1'b0};
      3'd4:    cmp_result = {~(lt | eq), 1'b0};
      3'd5:    cmp_result = {~lt, 1'b0};
      default: cmp_result = 2'b01;
    endcase
  endfunction

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] z_q, z_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              advance_s;
  logic              res_z_s;
  logic              res_err_s;
  logic              deliver_true_s;

  // Shift register advance; payload entering stage 0 is gated by in_valid so
  // bubbles always carry z=0/err=0 and the output reads 0 when not valid.
  always_comb begin
    advance_s = ~valid_q[STAGES-1] | bus.out_ready;
    {res_z_s, res_err_s} = cmp_result(bus.in_a, bus.in_b, bus.in_op, bus.in_signed);
    valid_d = valid_q;
    z_d     = z_q;
    err_d   = err_q;
    if (advance_s) begin
      valid_d = STAGES'({valid_q, bus.in_valid});
      z_d     = STAGES'({z_q, bus.in_valid & res_z_s});
      err_d   = STAGES'({err_q, bus.in_valid & res_err_s});
    end else begin
      valid_d = valid_q;
      z_d     = z_q;
      err_d   = err_q;
    end
  end

  // Saturating count of true results handed to the consumer.
  always_comb begin
    deliver_true_s = valid_q[STAGES-1] & bus.out_ready & z_q[STAGES-1];
    cnt_d = cnt_q;
    if (deliver_true_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {STAGES{1'b0}};
      z_q     <= {STAGES{1'b0}};
      err_q   <= {STAGES{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      z_q     <= z_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is forced high during reset: the pipeline is being emptied anyway.
  assign bus.in_ready   = advance_s | rst;
  assign bus.out_valid  = valid_q[STAGES-1];
  assign bus.out_z      = z_q[STAGES-1];
  assign bus.out_err    = err_q[STAGES-1];
  assign bus.true_count = cnt_q;
endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: three parameterisations driven in lockstep and scored against
// an arithmetic reference model with per-instance expected-result FIFOs.
module tb_cmp_pipe;
  localparam logic [2:0] OP_LT = 3'd0, OP_LE = 3'd1, OP_EQ = 3'd2;
  localparam logic [2:0] OP_GE = 3'd5, OP_R6 = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_s = 32'd0, b_s = 32'd0;
  logic [2:0]  op_s = 3'd0;
  logic        sgn_s = 1'b0, iv_s = 1'b0, ordy_s = 1'b1;

  always #5 clk = ~clk;

  cmp_pipe_if #(.WIDTH(32), .CNT_W(16)) if_a ();
  cmp_pipe_if #(.WIDTH(32), .CNT_W(2))  if_b ();
  cmp_pipe_if #(.WIDTH(8),  .CNT_W(16)) if_c ();

  cmp_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(2))  u_b (.clk(clk), .rst(rst), .bus(if_b));
  cmp_pipe #(.WIDTH(8),  .STAGES(4), .CNT_W(16)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.in_a = a_s;      assign if_b.in_a = a_s;      assign if_c.in_a = a_s[7:0];
  assign if_a.in_b = b_s;      assign if_b.in_b = b_s;      assign if_c.in_b = b_s[7:0];
  assign if_a.in_op = op_s;    assign if_b.in_op = op_s;    assign if_c.in_op = op_s;
  assign if_a.in_signed = sgn_s; assign if_b.in_signed = sgn_s; assign if_c.in_signed = sgn_s;
  assign if_a.in_valid = iv_s; assign if_b.in_valid = iv_s; assign if_c.in_valid = iv_s;
  assign if_a.out_ready = ordy_s; assign if_b.out_ready = ordy_s; assign if_c.out_ready = ordy_s;

  logic [2:0]  rdy_v, ov_v, oz_v, oe_v;
  logic [15:0] tc_v [3];
  assign rdy_v = {if_c.in_ready, if_b.in_ready, if_a.in_ready};
  assign ov_v  = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
  assign oz_v  = {if_c.out_z, if_b.out_z, if_a.out_z};
  assign oe_v  = {if_c.out_err, if_b.out_err, if_a.out_err};
  assign tc_v[0] = if_a.true_count;
  assign tc_v[1] = {14'd0, if_b.true_count};
  assign tc_v[2] = if_c.true_count;

  int wid [3] = '{32, 32, 8};
  int stg [3] = '{2, 1, 4};
  int cw  [3] = '{16, 2, 16};

  logic [1:0] fz [3][16];
  int         fc [3][16];
  int         hd [3] = '{0, 0, 0};
  int         tl [3] = '{0, 0, 0};
  int         cnt_m [3] = '{0, 0, 0};
  logic [1:0] log_a [$];
  int         cyc = 0;
  bit         strict = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Reference: operands as plain integers, signed view subtracts 2^w when the top bit is set.
  function automatic logic [1:0] ref_cmp(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic s);
    longint span, ua, ub, va, vb;
    span = longint'(1) << w;
    ua = longint'({32'd0, a}) & (span - 1);
    ub = longint'({32'd0, b}) & (span - 1);
    va = (s && ua >= span / 2) ? ua - span : ua;
    vb = (s && ub >= span / 2) ? ub - span : ub;
    case (op)
      3'd0: return {va < vb, 1'b0};
      3'd1: return {va <= vb, 1'b0};
      3'd2: return {va == vb, 1'b0};
      3'd3: return {va != vb, 1'b0};
      3'd4: return {va > vb, 1'b0};
      3'd5: return {va >= vb, 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  // One clock: drive at the falling edge, score outputs, update model, advance.
  task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [2:0] iop, input logic is, input logic rd);
    logic [1:0] got;
    int         h;
    iv_s = v; a_s = ia; b_s = ib; op_s = iop; sgn_s = is; ordy_s = rd;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rdy_v[k] !== (rst || !ov_v[k] || rd)) begin
        bad++;
        $display("FAIL in_ready inst=%0d cyc=%0d got=%b exp=%b", k, cyc, rdy_v[k], (rst || !ov_v[k] || rd));
      end
      if (!rst) begin
        got = {oz_v[k], oe_v[k]};
        total++;
        if (tc_v[k] !== 16'(cnt_m[k])) begin
          bad++;
          $display("FAIL true_count inst=%0d cyc=%0d got=%0d exp=%0d", k, cyc, tc_v[k], cnt_m[k]);
        end
        total++;
        if (ov_v[k] === 1'b1) begin
          h = hd[k] % 16;
          if (hd[k] == tl[k]) begin
            bad++;
            $display("FAIL unexpected_output inst=%0d cyc=%0d got=%b exp=none", k, cyc, got);
          end else begin
            if (got !== fz[k][h]) begin
              bad++;
              $display("FAIL result inst=%0d cyc=%0d got={z,err}=%b exp=%b", k, cyc, got, fz[k][h]);
            end
            if (rd) begin
              if (strict) begin
                total++;
                if (cyc - fc[k][h] != stg[k]) begin
                  bad++;
                  $display("FAIL latency inst=%0d cyc=%0d got=%0d exp=%0d", k, cyc, cyc - fc[k][h], stg[k]);
                end
              end
              if (fz[k][h][1] && cnt_m[k] < (1 << cw[k]) - 1) cnt_m[k]++;
              if (k == 0) log_a.push_back(got);
              hd[k]++;
            end
          end
        end else begin
          if (ov_v[k] !== 1'b0 || got !== 2'b00) begin
            bad++;
            $display("FAIL idle_output inst=%0d cyc=%0d got v/z/e=%b%b exp=000", k, cyc, ov_v[k], got);
          end
        end
        if (v && rdy_v[k]) begin
          fz[k][tl[k] % 16] = ref_cmp(wid[k], ia, ib, iop, is);
          fc[k][tl[k] % 16] = cyc;
          tl[k]++;
        end
      end
    end
    @(negedge clk);
    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        hd[k] = 0; tl[k] = 0; cnt_m[k] = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, OP_LT, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 32'd9, 32'd3, OP_GE, 1'b0, 1'b0);
    step(1'b1, 32'd1, 32'd3, OP_LT, 1'b1, 1'b1);
    step(1'b1, 32'd4, 32'd4, OP_EQ, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ov_v[k], oz_v[k], oe_v[k]} !== 3'b000 || tc_v[k] !== 16'd0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got v/z/e=%b%b%b cnt=%0d exp=000 cnt=0", k, ov_v[k], oz_v[k], oe_v[k], tc_v[k]);
      end
    end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_basic();
    strict = 1'b1;
    step(1'b1, 32'd5, 32'd5, OP_LE, 1'b0, 1'b1);
    total++;
    if (ov_v[0] !== 1'b0) begin bad++; $display("FAIL basic_early got=%b exp=0", ov_v[0]); end
    idle(1);
    total++;
    if (ov_v[0] !== 1'b1 || oz_v[0] !== 1'b1) begin
      bad++; $display("FAIL basic_lat2 got v/z=%b%b exp=11", ov_v[0], oz_v[0]);
    end
    idle(1);
    total++;
    if (tc_v[0] !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", tc_v[0]); end
    idle(4);
  endtask

  task automatic test_signed();
    logic [1:0] exp_l [6];
    exp_l = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    strict = 1'b1;
    log_a.delete();
    step(1'b1, 32'hFFFF_FFFF, 32'd1, OP_LT, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 32'd1, OP_LT, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 32'd1, OP_EQ, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 32'd1, OP_EQ, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, OP_LT, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, OP_LT, 1'b0, 1'b1);
    idle(6);
    total++;
    if (log_a.size() != 6) begin bad++; $display("FAIL signed_count got=%0d exp=6", log_a.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_a[i] !== exp_l[i]) begin
          bad++; $display("FAIL signed_result idx=%0d got=%b exp=%b", i, log_a[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_l [5];
    exp_l = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    strict = 1'b0;
    log_a.delete();
    step(1'b1, 32'd1, 32'd2, OP_LT, 1'b0, 1'b1);
    step(1'b1, 32'd2, 32'd1, OP_LT, 1'b0, 1'b1);
    step(1'b1, 32'd3, 32'd3, OP_EQ, 1'b0, 1'b1);
    step(1'b1, 32'd4, 32'd3, OP_EQ, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'd7, 32'd7, OP_GE, 1'b0, 1'b0);
      total++;
      if (rdy_v !== 3'b000 || ov_v[0] !== 1'b1 || oz_v[0] !== 1'b1) begin
        bad++; $display("FAIL bp_hold i=%0d got rdy=%b v/z=%b%b exp rdy=000 v/z=11", i, rdy_v, ov_v[0], oz_v[0]);
      end
    end
    step(1'b1, 32'd7, 32'd7, OP_GE, 1'b0, 1'b1);
    idle(7);
    total++;
    if (log_a.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", log_a.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (log_a[i] !== exp_l[i]) begin
          bad++; $display("FAIL bp_order idx=%0d got=%b exp=%b", i, log_a[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_reserved();
    logic [1:0] exp_l [3];
    exp_l = '{2'b10, 2'b01, 2'b10};
    strict = 1'b1;
    log_a.delete();
    step(1'b1, 32'd0, 32'd0, OP_EQ, 1'b0, 1'b1);
    step(1'b1, 32'd0, 32'd0, OP_R6, 1'b0, 1'b1);
    step(1'b1, 32'd0, 32'd0, OP_EQ, 1'b1, 1'b1);
    idle(6);
    total++;
    if (log_a.size() != 3) begin bad++; $display("FAIL rsv_count got=%0d exp=3", log_a.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (log_a[i] !== exp_l[i]) begin
          bad++; $display("FAIL rsv_result idx=%0d got=%b exp=%b", i, log_a[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    int exp_c [5];
    exp_c = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    strict = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'd1, 32'd1, OP_EQ, 1'b0, 1'b1);
      idle(1);
      total++;
      if (tc_v[1] !== 16'(exp_c[i])) begin
        bad++; $display("FAIL sat_count idx=%0d got=%0d exp=%0d", i, tc_v[1], exp_c[i]);
      end
    end
    idle(5);
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_r;
    strict = 1'b1;
    step(1'b1, 32'd3, 32'd3, OP_EQ, 1'b0, 1'b1);
    step(1'b1, 32'd2, 32'd8, OP_LT, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ov_v[k] !== 1'b0 || tc_v[k] !== 16'd0) begin
        bad++; $display("FAIL rstmid_flush inst=%0d got v=%b cnt=%0d exp v=0 cnt=0", k, ov_v[k], tc_v[k]);
      end
    end
    rst = 1'b0;
    log_a.delete();
    exp_r = ref_cmp(32, 32'hDEAD_BEEF, 32'h0000_BEEF, 3'd4, 1'b1);
    step(1'b1, 32'hDEAD_BEEF, 32'h0000_BEEF, 3'd4, 1'b1, 1'b1);
    idle(8);
    total++;
    if (log_a.size() != 1 || log_a[0] !== exp_r) begin
      bad++; $display("FAIL rstmid_after got n=%0d first=%b exp n=1 first=%b", log_a.size(),
                      (log_a.size() > 0) ? log_a[0] : 2'bxx, exp_r);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    strict = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i == 200) strict = 1'b0;
      ra = $urandom;
      if ($urandom_range(3) == 0) rb = ra;
      else if ($urandom_range(3) == 0) rb = ra ^ (32'd1 << $urandom_range(31));
      else rb = $urandom;
      step($urandom_range(3) != 0, ra, rb, 3'($urandom_range(7)), 1'($urandom_range(1)),
           (i < 200) ? 1'b1 : 1'($urandom_range(2) != 0));
    end
    idle(12);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (hd[k] != tl[k]) begin
        bad++; $display("FAIL random_drain inst=%0d got pending=%0d exp=0", k, tl[k] - hd[k]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_reserved();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
